// File: rtl/demux4_buf_if.sv
// Handshake bundle for demux4_buf: one producer port, four consumer slots, flush and busy.
interface demux4_buf_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_sel;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic [WIDTH-1:0] out_data3;
    logic             busy;

    modport master (
        output flush, in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, busy
    );

    modport slave (
        input  flush, in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, busy
    );
endinterface

// File: rtl/demux4_buf.sv
// Registered 1-to-4 demux with a one-entry holding slot per destination.
// Optional DEMUX4_BYPASS_EN: zero-latency pass-through into an empty, ready slot.
module demux4_buf_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic [WIDTH-1:0] data
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_st_e;

    slot_st_e st, st_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= EMPTY;
        else        st <= st_nxt;
    end

    // flush beats a refill, a refill beats a drain
    always_comb begin
        st_nxt = st;
        if (flush)   st_nxt = EMPTY;
        else if (wr) st_nxt = FULL;
        else if (rd) st_nxt = EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            data <= '0;
        else if (wr && !flush) data <= wdata;
    end

    assign full = (st == FULL);
endmodule

module demux4_buf #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            rst_n,
    demux4_buf_if.slave    bus
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0]            full;
    logic [NUM_LANES-1:0]            wr;
    logic [NUM_LANES-1:0]            byp_hit;
    logic [NUM_LANES-1:0][WIDTH-1:0] sdata;
    logic [NUM_LANES-1:0][WIDTH-1:0] odata;
    logic                            accept;
    logic                            byp;

    assign bus.in_ready = !bus.flush && (!full[bus.in_sel] || bus.out_ready[bus.in_sel]);
    assign accept       = bus.in_valid && bus.in_ready;

`ifdef DEMUX4_BYPASS_EN
    assign byp = !full[bus.in_sel] && bus.out_ready[bus.in_sel];
`else
    assign byp = 1'b0;
`endif

    genvar k;
    generate
        for (k = 0; k < NUM_LANES; k++) begin : g_lane
            // a bypassed word goes straight to the consumer and never lands in the slot
            assign wr[k]      = accept && (bus.in_sel == k[1:0]) && !byp;
            assign byp_hit[k] = accept && (bus.in_sel == k[1:0]) && byp;

            demux4_buf_slot #(.WIDTH(WIDTH)) u_slot (
                .clk   (clk),
                .rst_n (rst_n),
                .flush (bus.flush),
                .wr    (wr[k]),
                .rd    (bus.out_ready[k]),
                .wdata (bus.in_data),
                .full  (full[k]),
                .data  (sdata[k])
            );

            assign bus.out_valid[k] = full[k] || byp_hit[k];
            assign odata[k]         = byp_hit[k] ? bus.in_data : sdata[k];
        end
    endgenerate

    assign bus.out_data0 = odata[0];
    assign bus.out_data1 = odata[1];
    assign bus.out_data2 = odata[2];
    assign bus.out_data3 = odata[3];
    assign bus.busy      = |bus.out_valid;
endmodule

// File: tb/tb_demux4_buf.sv
// Scoreboard bench for demux4_buf: per-slot expected queues, negedge monitor pops on drain.
module tb_demux4_buf;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] q[4][$];
    logic [31:0] odata[4];

    demux4_buf_if #(.WIDTH(32)) bus();

    demux4_buf #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign odata[0] = bus.out_data0;
    assign odata[1] = bus.out_data1;
    assign odata[2] = bus.out_data2;
    assign odata[3] = bus.out_data3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every consumer handshake must deliver the oldest expected word of that slot
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.out_valid[k] && bus.out_ready[k]) begin
                    checks++;
                    if (q[k].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out%0d: got %h expected no word", k, odata[k]);
                    end else begin
                        logic [31:0] e;
                        e = q[k].pop_front();
                        if (odata[k] !== e) begin
                            errors++;
                            $display("FAIL out_data%0d: got %h expected %h", k, odata[k], e);
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_sel   = 2'd0;
        bus.in_data  = '0;
        bus.flush    = 1'b0;
    endtask

    // drive one word for one cycle, check in_ready against expectation, record if taken
    task automatic send(input logic [1:0] sel, input logic [31:0] d, input logic exp_rdy);
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = d;
        @(negedge clk);
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        if (exp_rdy) q[sel].push_back(d);
        step();
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.out_ready = 4'b0000;
        idle();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_valid", {28'd0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // 1: reset mid-operation discards a held word immediately
        send(2'd2, 32'hA5A5A5A5, 1'b1);
        @(negedge clk);
        chk("t1_out_valid", {28'd0, bus.out_valid}, 32'h4);
        chk("t1_out_data2", bus.out_data2, 32'hA5A5A5A5);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_rst_out_valid", {28'd0, bus.out_valid}, 32'd0);
        chk("t1_rst_out_data2", bus.out_data2, 32'd0);
        chk("t1_rst_busy", {31'd0, bus.busy}, 32'd0);
        for (int k = 0; k < 4; k++) q[k].delete();
        step();
        rst_n = 1'b1;
        step();

        // 2: routing to all four slots, then a fifth word stalls on a full slot
        send(2'd0, 32'h11, 1'b1);
        send(2'd1, 32'h22, 1'b1);
        send(2'd2, 32'h33, 1'b1);
        send(2'd3, 32'h44, 1'b1);
        @(negedge clk);
        chk("t2_out_valid", {28'd0, bus.out_valid}, 32'hF);
        chk("t2_busy", {31'd0, bus.busy}, 32'd1);
        chk("t2_data0", bus.out_data0, 32'h11);
        chk("t2_data1", bus.out_data1, 32'h22);
        chk("t2_data2", bus.out_data2, 32'h33);
        chk("t2_data3", bus.out_data3, 32'h44);
        step();
        send(2'd1, 32'h55, 1'b0);
        bus.out_ready = 4'b1111;
        step();
        bus.out_ready = 4'b0000;
        @(negedge clk);
        chk("t2_drained", {28'd0, bus.out_valid}, 32'd0);
        step();

        // 3: a stalled slot 1 does not block slot 3
        send(2'd1, 32'h66, 1'b1);
        send(2'd3, 32'h77, 1'b1);
        @(negedge clk);
        chk("t3_data3", bus.out_data3, 32'h77);
        chk("t3_data1", bus.out_data1, 32'h66);
        chk("t3_out_valid", {28'd0, bus.out_valid}, 32'hA);
        step();
        bus.out_ready = 4'b1111;
        step();

        // 4: back-to-back streaming into slot 2 with the consumer always ready
        for (int i = 1; i <= 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = 2'd2;
            bus.in_data  = i;
            @(negedge clk);
            chk("t4_in_ready", {31'd0, bus.in_ready}, 32'd1);
            q[2].push_back(i);
`ifdef DEMUX4_BYPASS_EN
            chk("t4_data2_lag0", bus.out_data2, i);
`else
            if (i > 1) chk("t4_data2_lag1", bus.out_data2, i - 1);
`endif
            step();
        end
        idle();
        @(negedge clk);
`ifndef DEMUX4_BYPASS_EN
        chk("t4_last", bus.out_data2, 32'd8);
`endif
        step();
        step();

        // 5: flush beats both the pending accept and the drains
        bus.out_ready = 4'b0000;
        send(2'd0, 32'h1000, 1'b1);
        send(2'd1, 32'h1001, 1'b1);
        send(2'd2, 32'h1002, 1'b1);
        send(2'd3, 32'h1003, 1'b1);
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        bus.in_data   = 32'hDEAD;
        bus.flush     = 1'b1;
        bus.out_ready = 4'b1111;
        @(negedge clk);
        chk("t5_in_ready", {31'd0, bus.in_ready}, 32'd0);
        step();
        idle();
        bus.out_ready = 4'b0000;
        @(negedge clk);
        chk("t5_out_valid", {28'd0, bus.out_valid}, 32'd0);
        chk("t5_busy", {31'd0, bus.busy}, 32'd0);
        chk("t5_data0_kept", bus.out_data0, 32'h1000);
        step();

        // 6: empty slot with a ready consumer: bypass is same-cycle, otherwise one cycle later
        bus.out_ready = 4'b0001;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        bus.in_data   = 32'hBEEF;
        @(negedge clk);
        chk("t6_in_ready", {31'd0, bus.in_ready}, 32'd1);
        q[0].push_back(32'hBEEF);
`ifdef DEMUX4_BYPASS_EN
        chk("t6_valid_now", {31'd0, bus.out_valid[0]}, 32'd1);
        chk("t6_data_now", bus.out_data0, 32'hBEEF);
`else
        chk("t6_valid_now", {31'd0, bus.out_valid[0]}, 32'd0);
`endif
        step();
        idle();
        @(negedge clk);
`ifdef DEMUX4_BYPASS_EN
        chk("t6_valid_next", {31'd0, bus.out_valid[0]}, 32'd0);
`else
        chk("t6_valid_next", {31'd0, bus.out_valid[0]}, 32'd1);
        chk("t6_data_next", bus.out_data0, 32'hBEEF);
`endif
        step();
        step();
        bus.out_ready = 4'b0000;

        for (int k = 0; k < 4; k++) chk("leftover", q[k].size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
